// File: rtl/instr_prefetch_queue_if.sv
// Bundles the memory-side and decode-side signals of the instruction
// prefetch queue. The master modport is the fetch unit itself; the slave
// modport is whatever sits around it (memory plus decode).
interface instr_prefetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    // Instruction memory side
    logic                     instr_mem_ready_i;
    logic [DATA_W-1:0]        instr_mem_data_i;
    logic [ADDR_W-1:0]        instr_mem_addr_o;
    logic                     instr_mem_rd_o;
    // Redirect (branch / jump / trap)
    logic                     redirect_i;
    logic [ADDR_W-1:0]        redirect_addr_i;
    // Decode side
    logic                     instr_valid_o;
    logic [DATA_W-1:0]        instr_o;
    logic [ADDR_W-1:0]        instr_addr_o;
    logic                     instr_ready_i;
    logic [$clog2(DEPTH):0]   count_o;

    modport master (
        input  instr_mem_ready_i, instr_mem_data_i, redirect_i,
               redirect_addr_i, instr_ready_i,
        output instr_mem_addr_o, instr_mem_rd_o, instr_valid_o,
               instr_o, instr_addr_o, count_o
    );

    modport slave (
        output instr_mem_ready_i, instr_mem_data_i, redirect_i,
               redirect_addr_i, instr_ready_i,
        input  instr_mem_addr_o, instr_mem_rd_o, instr_valid_o,
               instr_o, instr_addr_o, count_o
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues sequential reads
// and buffers {address, word} pairs in a DEPTH-entry in-order FIFO so that
// decode stalls and memory wait states are decoupled. A redirect flushes
// the queue and restarts fetch at a word-aligned address.
module instr_prefetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    instr_prefetch_queue_if.master bus
);
    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_pc;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];

    logic w_pop;
    logic w_rd;
    logic w_push;

    // Handshake decode: a pop frees a slot in the same cycle, so a full
    // queue being drained may still fetch (instr_ready_i -> rd is combinational).
    // Reset and redirect kill the request immediately.
    always_comb begin
        w_pop  = (r_count != {CNT_W{1'b0}}) & bus.instr_ready_i;
        w_rd   = ~rst_i & ~bus.redirect_i & ((r_count < FULL_CNT) | w_pop);
        w_push = w_rd & bus.instr_mem_ready_i;
    end

    // FIFO storage: capture {PC, word} at the tail on every accepted fetch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_addr[i] <= {ADDR_W{1'b0}};
                r_mem_data[i] <= {DATA_W{1'b0}};
            end
        end else if (w_push) begin
            r_mem_addr[r_wr_ptr] <= r_pc;
            r_mem_data[r_wr_ptr] <= bus.instr_mem_data_i;
        end else begin
            r_mem_addr[r_wr_ptr] <= r_mem_addr[r_wr_ptr];
            r_mem_data[r_wr_ptr] <= r_mem_data[r_wr_ptr];
        end
    end

    // PC, pointers and occupancy; a redirect overrides everything else.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc     <= RESET_PC;
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else if (bus.redirect_i) begin
            r_pc     <= {bus.redirect_addr_i[ADDR_W-1:2], 2'b00};
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_pc     <= r_pc + ADDR_W'(4);
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end else begin
                r_pc     <= r_pc;
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Head outputs are a read of the registered storage, so they only move
    // after a pop or a push into an empty queue.
    assign bus.instr_mem_addr_o = r_pc;
    assign bus.instr_mem_rd_o   = w_rd;
    assign bus.instr_valid_o    = (r_count != {CNT_W{1'b0}});
    assign bus.instr_o          = r_mem_data[r_rd_ptr];
    assign bus.instr_addr_o     = r_mem_addr[r_rd_ptr];
    assign bus.count_o          = r_count;
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue (DEPTH=4, RESET_PC=0). The
// memory model returns the fetch address as the instruction word.
module tb_instr_prefetch_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    instr_prefetch_queue_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) bus_if ();

    instr_prefetch_queue #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    // Clock generation
    always #5 clk = ~clk;

    // Memory model: word at address A is A
    assign bus_if.instr_mem_data_i = bus_if.instr_mem_addr_o;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_if.redirect_i        = 1'b0;
        bus_if.redirect_addr_i   = 32'h0;
        bus_if.instr_ready_i     = 1'b0;
        bus_if.instr_mem_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [31:0] addr, input logic [4:0] cnt);
        check_val({tag, "_valid"}, {63'd0, bus_if.instr_valid_o}, 64'd1);
        check_val({tag, "_addr"}, {32'd0, bus_if.instr_addr_o}, {32'd0, addr});
        check_val({tag, "_instr"}, {32'd0, bus_if.instr_o}, {32'd0, addr});
        check_val({tag, "_count"}, {59'd0, bus_if.count_o}, {59'd0, cnt});
    endtask

    initial begin
        bus_if.redirect_i        = 1'b0;
        bus_if.redirect_addr_i   = 32'h0;
        bus_if.instr_ready_i     = 1'b0;
        bus_if.instr_mem_ready_i = 1'b0;

        // 1. Reset state, then streaming at one word per cycle
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_valid", {63'd0, bus_if.instr_valid_o}, 64'd0);
        check_val("rst_count", {61'd0, bus_if.count_o}, 64'd0);
        check_val("rst_rd", {63'd0, bus_if.instr_mem_rd_o}, 64'd0);
        check_val("rst_instr", {32'd0, bus_if.instr_o}, 64'd0);
        check_val("rst_iaddr", {32'd0, bus_if.instr_addr_o}, 64'd0);
        check_val("rst_maddr", {32'd0, bus_if.instr_mem_addr_o}, 64'd0);
        rst = 1'b0;
        bus_if.instr_mem_ready_i = 1'b1;
        bus_if.instr_ready_i     = 1'b1;
        #1;
        check_val("t1_rd", {63'd0, bus_if.instr_mem_rd_o}, 64'd1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_head("t1", 32'(4 * (k - 1)), 5'd1);
        end

        // 2. Decode stalled: fills to 4, then drains in order
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_val("t2_fill", {59'd0, 5'(bus_if.count_o)}, 64'(k));
        end
        check_val("t2_rd_full", {63'd0, bus_if.instr_mem_rd_o}, 64'd0);
        check_val("t2_maddr", {32'd0, bus_if.instr_mem_addr_o}, 64'h10);
        tick();
        tick();
        check_head("t2_hold", 32'h0, 5'd4);
        bus_if.instr_ready_i = 1'b1;
        #1;
        check_val("t2_rd_pop", {63'd0, bus_if.instr_mem_rd_o}, 64'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_head("t2_drain", 32'(4 * k), 5'd4);
        end

        // 3. Redirect flushes the queue, aligns the target
        do_reset();
        repeat (3) tick();
        check_val("t3_count", {61'd0, bus_if.count_o}, 64'd3);
        bus_if.redirect_i      = 1'b1;
        bus_if.redirect_addr_i = 32'h103;
        #1;
        check_val("t3_rd_redir", {63'd0, bus_if.instr_mem_rd_o}, 64'd0);
        tick();
        bus_if.redirect_i = 1'b0;
        check_val("t3_valid", {63'd0, bus_if.instr_valid_o}, 64'd0);
        check_val("t3_cnt0", {61'd0, bus_if.count_o}, 64'd0);
        check_val("t3_maddr", {32'd0, bus_if.instr_mem_addr_o}, 64'h100);
        tick();
        check_head("t3_first", 32'h100, 5'd1);

        // 4. Memory wait states mid-stream
        do_reset();
        bus_if.instr_ready_i = 1'b1;
        repeat (3) tick();
        check_head("t4_pre", 32'h8, 5'd1);
        bus_if.instr_ready_i     = 1'b0;
        bus_if.instr_mem_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("t4_maddr", {32'd0, bus_if.instr_mem_addr_o}, 64'hC);
            check_val("t4_rd", {63'd0, bus_if.instr_mem_rd_o}, 64'd1);
            check_head("t4_wait", 32'h8, 5'd1);
        end
        bus_if.instr_ready_i     = 1'b1;
        bus_if.instr_mem_ready_i = 1'b1;
        tick();
        check_head("t4_res0", 32'hC, 5'd1);
        tick();
        check_head("t4_res1", 32'h10, 5'd1);

        // 5. PC wraps at the top of the address space
        do_reset();
        bus_if.instr_ready_i   = 1'b1;
        bus_if.redirect_i      = 1'b1;
        bus_if.redirect_addr_i = 32'hFFFF_FFF8;
        tick();
        bus_if.redirect_i = 1'b0;
        check_val("t5_maddr", {32'd0, bus_if.instr_mem_addr_o}, 64'hFFFF_FFF8);
        tick();
        check_head("t5_w0", 32'hFFFF_FFF8, 5'd1);
        tick();
        check_head("t5_w1", 32'hFFFF_FFFC, 5'd1);
        check_val("t5_wrap", {32'd0, bus_if.instr_mem_addr_o}, 64'h0);
        tick();
        check_head("t5_w2", 32'h0, 5'd1);

        // 6. Asynchronous reset during an outstanding request
        do_reset();
        repeat (3) tick();
        check_val("t6_cnt3", {61'd0, bus_if.count_o}, 64'd3);
        check_val("t6_rd1", {63'd0, bus_if.instr_mem_rd_o}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("t6_rd0", {63'd0, bus_if.instr_mem_rd_o}, 64'd0);
        check_val("t6_cnt0", {61'd0, bus_if.count_o}, 64'd0);
        check_val("t6_valid", {63'd0, bus_if.instr_valid_o}, 64'd0);
        check_val("t6_iaddr", {32'd0, bus_if.instr_addr_o}, 64'd0);
        check_val("t6_maddr", {32'd0, bus_if.instr_mem_addr_o}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_val("t6_rel_maddr", {32'd0, bus_if.instr_mem_addr_o}, 64'd0);
        tick();
        check_head("t6_first", 32'h0, 5'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
